// File: rtl/cdf_compute.sv
`default_nettype none
// ============================================================================
// Module   : cdf_compute
// Purpose  : Cumulative-distribution stage of the histogram equalizer.
//            On start_cdf it streams NUM_BINS histogram counts out of scratch
//            memory, forms the saturating running prefix sum, writes each CDF
//            value back to scratch memory and captures cdf_min (first nonzero
//            CDF value) for the divider stage.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock                       in   1       rising-edge clock
//   reset                       in   1       asynchronous active-high reset
//   start_cdf                   in   1       start pulse (accepted in IDLE only)
//   cdf_scratch_mem_read_addr0  out  ADDR_W  read address, port 0
//   cdf_scratch_mem_read_addr1  out  ADDR_W  read address, port 1 (tied 0)
//   cdf_scratch_mem_rdata0      in   CNT_W   read data, 1 cycle after address
//   cdf_scratch_mem_rdata1      in   CNT_W   unused
//   cdf_scratch_mem_waddr       out  ADDR_W  write address
//   cdf_scratch_mem_wdata       out  CNT_W   write data (CDF value)
//   cdf_scratch_mem_WE          out  1       write enable
//   cdf_busy                    out  1       run in progress
//   cdf_computation_done        out  1       1-cycle completion pulse
//   cdf_min                     out  CNT_W   first nonzero CDF value
//   cdf_overflow                out  1       sticky prefix-sum saturation flag
//   expected_total              in   CNT_W   pixel count for the total check
//   cdf_total_error             out  1       final CDF != expected_total
// Build option
//   CDF_TOTAL_CHECK_EN : when defined, the final CDF value is compared against
//                        expected_total in the DONE cycle; otherwise
//                        cdf_total_error is tied 0 and no comparator exists.
// ============================================================================
module cdf_compute #(
    parameter int NUM_BINS  = 256,
    parameter int CNT_W     = 32,
    parameter int ADDR_W    = 16,
    parameter int HIST_BASE = 0,
    parameter int CDF_BASE  = 256
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start_cdf,
    output logic [ADDR_W-1:0] cdf_scratch_mem_read_addr0,
    output logic [ADDR_W-1:0] cdf_scratch_mem_read_addr1,
    input  logic [CNT_W-1:0]  cdf_scratch_mem_rdata0,
    input  logic [CNT_W-1:0]  cdf_scratch_mem_rdata1,
    output logic [ADDR_W-1:0] cdf_scratch_mem_waddr,
    output logic [CNT_W-1:0]  cdf_scratch_mem_wdata,
    output logic              cdf_scratch_mem_WE,
    output logic              cdf_busy,
    output logic              cdf_computation_done,
    output logic [CNT_W-1:0]  cdf_min,
    output logic              cdf_overflow,
    input  logic [CNT_W-1:0]  expected_total,
    output logic              cdf_total_error
);

    localparam int                 c_IDX_W     = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX  = c_IDX_W'(NUM_BINS - 1);
    localparam logic [ADDR_W-1:0]  c_HIST_BASE = ADDR_W'(HIST_BASE);
    localparam logic [ADDR_W-1:0]  c_CDF_BASE  = ADDR_W'(CDF_BASE);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_READ  = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic               w_start;

    logic [c_IDX_W-1:0] r_idx;        // bin whose read is being issued
    logic [ADDR_W-1:0]  r_raddr;
    logic               r_rd_vld;     // rdata0 carries a bin this cycle
    logic [c_IDX_W-1:0] r_rd_idx;     // bin index matching rdata0
    logic               r_drain;      // second DRAIN cycle marker

    logic [CNT_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_min;
    logic               r_min_found;
    logic               r_ovf;

    logic               r_we;
    logic [ADDR_W-1:0]  r_waddr;
    logic [CNT_W-1:0]   r_wdata;

    logic [CNT_W:0]     w_sum;
    logic [CNT_W-1:0]   w_acc_next;

    assign w_start = (r_state == c_IDLE) && start_cdf;

    // One extra bit catches the carry; once saturated the sum stays pinned
    // at all-ones for the rest of the run.
    assign w_sum      = {1'b0, r_acc} + {1'b0, cdf_scratch_mem_rdata0};
    assign w_acc_next = (w_sum[CNT_W] || r_ovf) ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];

    // ------------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (start_cdf)            w_state_next = c_READ;
            c_READ:  if (r_idx == c_LAST_IDX)  w_state_next = c_DRAIN;
            c_DRAIN: if (r_drain)              w_state_next = c_DONE;
            c_DONE:                            w_state_next = c_IDLE;
            default:                           w_state_next = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Read issue, accumulate and write-back pipeline
    //   cycle 1+i : read address of bin i
    //   cycle 2+i : rdata0 valid, accumulator updated at end of cycle
    //   cycle 3+i : registered write of CDF[i]
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_idx       <= '0;
            r_raddr     <= '0;
            r_rd_vld    <= 1'b0;
            r_rd_idx    <= '0;
            r_drain     <= 1'b0;
            r_acc       <= '0;
            r_min       <= '0;
            r_min_found <= 1'b0;
            r_ovf       <= 1'b0;
            r_we        <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
        end else begin
            r_rd_vld <= (r_state == c_READ);
            r_rd_idx <= r_idx;
            r_we     <= 1'b0;
            r_drain  <= (r_state == c_DRAIN) ? ~r_drain : 1'b0;

            if (w_start) begin
                r_idx       <= '0;
                r_raddr     <= c_HIST_BASE;
                r_acc       <= '0;
                r_min       <= '0;
                r_min_found <= 1'b0;
                r_ovf       <= 1'b0;
            end

            // The address register is only advanced inside READ, so it holds
            // the last issued address once the run leaves READ.
            if ((r_state == c_READ) && (r_idx != c_LAST_IDX)) begin
                r_idx   <= r_idx + c_IDX_W'(1);
                r_raddr <= c_HIST_BASE + ADDR_W'(r_idx) + ADDR_W'(1);
            end

            if (r_rd_vld) begin
                r_acc   <= w_acc_next;
                r_we    <= 1'b1;
                r_waddr <= c_CDF_BASE + ADDR_W'(r_rd_idx);
                r_wdata <= w_acc_next;
                if (w_sum[CNT_W]) begin
                    r_ovf <= 1'b1;
                end
                if (!r_min_found && (w_acc_next != '0)) begin
                    r_min       <= w_acc_next;
                    r_min_found <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Optional final-total check
    // ------------------------------------------------------------------------
    logic w_unused;

`ifdef CDF_TOTAL_CHECK_EN
    logic r_total_err;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_total_err <= 1'b0;
        end else if (w_start) begin
            r_total_err <= 1'b0;
        end else if (r_state == c_DONE) begin
            r_total_err <= (r_acc != expected_total);
        end
    end

    assign cdf_total_error = r_total_err;
    assign w_unused        = ^cdf_scratch_mem_rdata1;
`else
    assign cdf_total_error = 1'b0;
    assign w_unused        = ^{cdf_scratch_mem_rdata1, expected_total};
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign cdf_scratch_mem_read_addr0 = r_raddr;
    assign cdf_scratch_mem_read_addr1 = '0;
    assign cdf_scratch_mem_waddr      = r_waddr;
    assign cdf_scratch_mem_wdata      = r_wdata;
    assign cdf_scratch_mem_WE         = r_we;
    assign cdf_busy                   = (r_state != c_IDLE);
    assign cdf_computation_done       = (r_state == c_DONE);
    assign cdf_min                    = r_min;
    assign cdf_overflow               = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_cdf_compute.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdf_compute
// Purpose  : Self-checking bench for cdf_compute. A 32-bit instance and an
//            8-bit instance share a behavioural scratch-memory model; the
//            expected write stream, cdf_min and overflow come from a plain
//            saturating prefix-sum model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdf_compute;

    localparam int NB = 256;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        sel;               // 0: 32-bit instance, 1: 8-bit instance
    logic [31:0] expected_total;
    logic [31:0] rdata1;

    logic        start_a, start_b;
    logic [15:0] raddr0_a, raddr1_a, waddr_a;
    logic [31:0] rdata0_a, wdata_a, min_a;
    logic        we_a, busy_a, done_a, ovf_a, terr_a;
    logic [15:0] raddr0_b, raddr1_b, waddr_b;
    logic [7:0]  rdata0_b, wdata_b, min_b;
    logic        we_b, busy_b, done_b, ovf_b, terr_b;

    logic [31:0] hist_a [NB];
    logic [7:0]  hist_b [NB];

    logic [15:0] raddr0, raddr1, waddr;
    logic [31:0] wdata, cmin;
    logic        we, busy, done, ovf, terr;

    int n_vec = 0;
    int n_err = 0;

    longint hist_m  [NB];
    longint exp_cdf [NB];
    longint exp_min;
    longint exp_final;
    bit     exp_ovf;

    always #5 clock = ~clock;

    assign start_a = start & ~sel;
    assign start_b = start & sel;

    assign raddr0 = sel ? raddr0_b : raddr0_a;
    assign raddr1 = sel ? raddr1_b : raddr1_a;
    assign waddr  = sel ? waddr_b  : waddr_a;
    assign wdata  = sel ? {24'd0, wdata_b} : wdata_a;
    assign cmin   = sel ? {24'd0, min_b}   : min_a;
    assign we     = sel ? we_b   : we_a;
    assign busy   = sel ? busy_b : busy_a;
    assign done   = sel ? done_b : done_a;
    assign ovf    = sel ? ovf_b  : ovf_a;
    assign terr   = sel ? terr_b : terr_a;

    cdf_compute #(.NUM_BINS(NB), .CNT_W(32), .ADDR_W(16), .HIST_BASE(0), .CDF_BASE(256)) u_dut_a (
        .clock                      (clock),
        .reset                      (reset),
        .start_cdf                  (start_a),
        .cdf_scratch_mem_read_addr0 (raddr0_a),
        .cdf_scratch_mem_read_addr1 (raddr1_a),
        .cdf_scratch_mem_rdata0     (rdata0_a),
        .cdf_scratch_mem_rdata1     (rdata1),
        .cdf_scratch_mem_waddr      (waddr_a),
        .cdf_scratch_mem_wdata      (wdata_a),
        .cdf_scratch_mem_WE         (we_a),
        .cdf_busy                   (busy_a),
        .cdf_computation_done       (done_a),
        .cdf_min                    (min_a),
        .cdf_overflow               (ovf_a),
        .expected_total             (expected_total),
        .cdf_total_error            (terr_a)
    );

    cdf_compute #(.NUM_BINS(NB), .CNT_W(8), .ADDR_W(16), .HIST_BASE(0), .CDF_BASE(256)) u_dut_b (
        .clock                      (clock),
        .reset                      (reset),
        .start_cdf                  (start_b),
        .cdf_scratch_mem_read_addr0 (raddr0_b),
        .cdf_scratch_mem_read_addr1 (raddr1_b),
        .cdf_scratch_mem_rdata0     (rdata0_b),
        .cdf_scratch_mem_rdata1     (rdata1[7:0]),
        .cdf_scratch_mem_waddr      (waddr_b),
        .cdf_scratch_mem_wdata      (wdata_b),
        .cdf_scratch_mem_WE         (we_b),
        .cdf_busy                   (busy_b),
        .cdf_computation_done       (done_b),
        .cdf_min                    (min_b),
        .cdf_overflow               (ovf_b),
        .expected_total             (expected_total[7:0]),
        .cdf_total_error            (terr_b)
    );

    // Scratch memory read port: one cycle of latency, histogram at 0..NB-1.
    always @(posedge clock) begin
        rdata0_a <= (raddr0_a < 16'(NB)) ? hist_a[raddr0_a[7:0]] : 32'hBAD0_BAD0;
        rdata0_b <= (raddr0_b < 16'(NB)) ? hist_b[raddr0_b[7:0]] : 8'hBD;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Histogram patterns: 0 ramp, 1 zeros, 2 single bin 200, 3 sparse random,
    // 4 full-range random, 5 all ones, 6 small random.
    task automatic load(input int pat);
        for (int i = 0; i < NB; i++) begin
            case (pat)
                0:       hist_m[i] = i;
                1:       hist_m[i] = 0;
                2:       hist_m[i] = (i == 200) ? 65536 : 0;
                3:       hist_m[i] = (i < 5 || $urandom_range(0, 3) == 0) ? 0 : longint'($urandom_range(1, 1000));
                4:       hist_m[i] = longint'($urandom);
                5:       hist_m[i] = 1;
                default: hist_m[i] = longint'($urandom_range(0, 3));
            endcase
            hist_a[i] = hist_m[i][31:0];
            hist_b[i] = hist_m[i][7:0];
        end
    endtask

    task automatic model();
        longint mx;
        longint sum;
        bit     found;
        mx      = sel ? 64'd255 : 64'hFFFF_FFFF;
        sum     = 0;
        found   = 0;
        exp_min = 0;
        exp_ovf = 0;
        for (int i = 0; i < NB; i++) begin
            sum = sum + hist_m[i];
            if (sum > mx) begin
                sum     = mx;
                exp_ovf = 1;
            end
            exp_cdf[i] = sum;
            if (!found && sum != 0) begin
                exp_min = sum;
                found   = 1;
            end
        end
        exp_final = sum;
    endtask

    task automatic run(input int pat, input bit repulse, input bit bump);
        int n, done_cyc, first_we, last_we, wcnt, busy_cnt, idx;
        bit exp_terr;
        load(pat);
        model();
        expected_total = 32'(exp_final) + (bump ? 32'd1 : 32'd0);
        rdata1         = $urandom;
`ifdef CDF_TOTAL_CHECK_EN
        exp_terr = bump;
`else
        exp_terr = 1'b0;
`endif
        done_cyc = -1; first_we = -1; last_we = -1; wcnt = 0; busy_cnt = 0;
        @(negedge clock);
        start = 1'b1;
        chk("busy_cycle0", busy, 0);
        n = 0;
        while (done_cyc < 0 && n < 400) begin
            @(negedge clock);
            n++;
            start = repulse && (n == 50 || n == 259);
            if (busy) busy_cnt++;
            if (n <= NB) chk("read_addr0", raddr0, n - 1);
            if (we) begin
                wcnt++;
                if (first_we < 0) first_we = n;
                last_we = n;
                idx = n - 3;
                if (idx >= 0 && idx < NB) begin
                    chk("waddr", waddr, 256 + idx);
                    chk("wdata", wdata, exp_cdf[idx]);
                end
            end
            if (done) done_cyc = n;
        end
        chk("done_cycle", done_cyc, 259);
        chk("busy_cycles", busy_cnt, 259);
        chk("we_count", wcnt, 256);
        chk("we_first", first_we, 3);
        chk("we_last", last_we, 258);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            start = 1'b0;
            chk("post_we", we, 0);
            chk("post_busy", busy, 0);
            chk("post_done", done, 0);
        end
        chk("cdf_min", cmin, exp_min);
        chk("cdf_overflow", ovf, exp_ovf);
        chk("cdf_total_error", terr, exp_terr);
        chk("read_addr0_hold", raddr0, 255);
        chk("read_addr1", raddr1, 0);
    endtask

    task automatic reset_mid_run();
        int we_cnt, done_cnt, busy_cnt;
        load(0);
        @(negedge clock);
        start = 1'b1;
        for (int n = 1; n < 100; n++) begin
            @(negedge clock);
            start = 1'b0;
        end
        @(negedge clock);                 // cycle 100
        chk("we_before_reset", we, 1);
        reset = 1'b1;
        #1;
        chk("we_at_reset", we, 0);
        chk("busy_at_reset", busy, 0);
        chk("done_at_reset", done, 0);
        @(negedge clock);
        reset = 1'b0;
        we_cnt = 0; done_cnt = 0; busy_cnt = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clock);
            if (we)   we_cnt++;
            if (done) done_cnt++;
            if (busy) busy_cnt++;
        end
        chk("we_after_reset", we_cnt, 0);
        chk("done_after_reset", done_cnt, 0);
        chk("busy_after_reset", busy_cnt, 0);
    endtask

    initial begin
        reset          = 1'b1;
        start          = 1'b0;
        sel            = 1'b0;
        expected_total = '0;
        rdata1         = '0;
        for (int i = 0; i < NB; i++) begin
            hist_a[i] = '0;
            hist_b[i] = '0;
        end
        @(negedge clock);
        @(negedge clock);
        chk("rst_read_addr0", raddr0, 0);
        chk("rst_read_addr1", raddr1, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_we", we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_min", cmin, 0);
        chk("rst_overflow", ovf, 0);
        chk("rst_total_error", terr, 0);
        reset = 1'b0;

        run(0, 1'b0, 1'b0);   // ramp: CDF[255] = 32640, cdf_min = 1
        run(0, 1'b0, 1'b1);   // ramp with expected_total = 32641
        run(1, 1'b0, 1'b0);   // all bins empty
        run(2, 1'b0, 1'b0);   // single bin 200 = 65536
        run(3, 1'b0, 1'b0);   // sparse random
        run(4, 1'b1, 1'b0);   // full-range random (saturates), start re-pulsed
        reset_mid_run();
        run(3, 1'b0, 1'b0);   // clean run after mid-run reset

        sel = 1'b1;
        run(5, 1'b0, 1'b0);   // 8-bit: all ones, CDF[255] saturates to 255
        run(6, 1'b1, 1'b0);   // 8-bit: small random, start re-pulsed

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
